ysyx_24120013_mem_arbiter: RTL and testbench
============================================

# ysyx_24120013_mem_arbiter

Sequencing arbiter that shares the core's single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU). It accepts one request at a time over a valid/ready handshake and issues it to memory. It waits for the memory response, with a watchdog, and routes the response back to the requester that owns the transaction. It sits between the IFU/LSU and the memory interface and replaces the direct `pmem` feed into the fetch unit.

## Interface
- `ADDR_WIDTH`, 32, address width
- `DATA_WIDTH`, 32, data width
- `TIMEOUT`, 255, cycles in WAIT before an error response (≥1)

- `clk`  in  1  clock, rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `ifu_req_valid`  in  1  fetch request
- `ifu_req_ready`  out  1  fetch request accepted
- `ifu_addr`  in  ADDR_WIDTH  fetch address
- `ifu_resp_valid`  out  1  fetch response pulse
- `ifu_rdata`  out  DATA_WIDTH  fetched instruction
- `ifu_resp_err`  out  1  fetch timed out
- `lsu_req_valid`  in  1  load/store request
- `lsu_req_ready`  out  1  load/store accepted
- `lsu_addr`  in  ADDR_WIDTH  load/store address
- `lsu_wen`  in  1  1 = store
- `lsu_wdata`  in  DATA_WIDTH  store data
- `lsu_wmask`  in  DATA_WIDTH/8  byte enables
- `lsu_resp_valid`  out  1  load/store response pulse
- `lsu_rdata`  out  DATA_WIDTH  load data (don't-care for stores)
- `lsu_resp_err`  out  1  load/store timed out
- `mem_req_valid`  out  1  request to memory
- `mem_req_ready`  in  1  memory accepts request
- `mem_addr`  out  ADDR_WIDTH  address
- `mem_wen`  out  1  write enable
- `mem_wdata`  out  DATA_WIDTH  write data
- `mem_wmask`  out  DATA_WIDTH/8  byte enables
- `mem_resp_valid`  in  1  memory response
- `mem_rdata`  in  DATA_WIDTH  read data
- `busy`  out  1  transaction outstanding (state ≠ IDLE)

## Operation
- The FSM has three states: IDLE, ISSUE, WAIT. Reset enters IDLE.
- **IDLE:** `*_req_ready` is combinational and asserted only for the arbitration winner.
  - Single valid requester: that requester wins.
  - Both valid: round-robin. The winner is the requester not granted last.
  - `last_grant` resets to LSU, so IFU wins the first tie after reset.
  - On handshake (valid & ready):
    - latch owner, addr, wen, wdata and wmask;
    - update `last_grant`;
    - go to ISSUE.
  - IFU requests are latched with wen=0 and wmask=all-ones.
- **ISSUE:**
  - `mem_req_valid=1`, and `mem_*` are driven from the latched registers.
  - They stay stable until `mem_req_ready`; then go to WAIT and clear the watchdog counter.
  - `mem_resp_valid` in ISSUE is ignored (protocol violation).
- **WAIT:**
  - On `mem_resp_valid`: register a response to the owner with `rdata=mem_rdata` and `err=0`; go to IDLE.
  - Otherwise the counter increments. When it equals TIMEOUT, register the response with `rdata=0` and `err=1`, then go to IDLE.
  - If `mem_resp_valid` arrives in the same cycle as the timeout, the data response wins (`err=0`).
- `mem_resp_valid` in IDLE (a late response after a timeout) is dropped.
- The counter width is `$clog2(TIMEOUT+1)`. It is saturation-free because it exits at TIMEOUT.
- The response path has no back-pressure; requesters must accept `*_resp_valid` unconditionally.
- The non-owner's `resp_valid` never asserts.

## Timing
- Reset values:
  - state = IDLE;
  - all `*_resp_valid`, `*_resp_err` = 0;
  - `*_rdata` = 0;
  - `mem_req_valid` = 0; `mem_addr`/`wdata`/`wmask`/`wen` = 0;
  - `busy` = 0;
  - counter = 0.
- Reset mid-transaction drops the outstanding request immediately. No response is produced.
- Response outputs are registered and `*_resp_valid` is a one-cycle pulse. `rdata` and `err` hold until the next response.
- With `mem_req_ready=1` and a response in the first WAIT cycle:
  - handshake in cycle 0;
  - `mem_req_valid` in cycle 1;
  - `mem_resp_valid` in cycle 2;
  - `*_resp_valid` in cycle 3.
- Minimum latency is 3 cycles. The cycle-3 response cycle is IDLE, so a new grant is possible in cycle 3 and throughput is 1 transaction per 3 cycles.
- Timeout: `err` response `TIMEOUT+1` cycles after entering WAIT.
- Requests held valid while the arbiter is busy are not acknowledged (`ready=0` outside IDLE) and must stay stable.

## Test plan
- **Single fetch.** IFU requests addr 0x80000000; memory readies immediately and returns 0x00100093 one cycle later. Expect `ifu_resp_valid` in cycle 3, `ifu_rdata=0x00100093`, `err=0`, `lsu_resp_valid=0` throughout.
- **Round-robin tie.** After reset, IFU and LSU are both valid continuously. Expect grant order IFU, LSU, IFU, LSU, each handshake 3 cycles apart, with owners matching the responses.
- **Store pass-through.** LSU store: addr 0x80001000, wdata 0xDEADBEEF, wmask 0b0011; `mem_req_ready` is held low for 4 cycles. Expect `mem_*` stable and `mem_req_valid=1` for 5 cycles, then `lsu_resp_valid` one cycle after `mem_resp_valid`.
- **Timeout.** `TIMEOUT=4`, memory never responds. Expect `lsu_resp_valid` with `err=1` and `rdata=0` five cycles after entering WAIT. A later `mem_resp_valid` in IDLE produces no response.
- **Timeout/response collision.** `mem_resp_valid` (data 0x12345678) arrives in the same cycle the counter hits TIMEOUT. Expect `err=0` and `rdata=0x12345678`.
- **Reset mid-transaction.** Assert `rst` asynchronously during WAIT. Expect all outputs at reset values immediately, no response pulse, and the next tie granted to IFU.

Source files
------------

// File: rtl/ysyx_24120013_mem_arbiter_if.sv
// Bundle of the IFU/LSU request-response channels and the shared memory port.
// The slave view belongs to the arbiter; the master view belongs to the requesters and the memory.
interface ysyx_24120013_mem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                      ifu_req_valid;
  logic                      ifu_req_ready;
  logic [ADDR_WIDTH-1:0]     ifu_addr;
  logic                      ifu_resp_valid;
  logic [DATA_WIDTH-1:0]     ifu_rdata;
  logic                      ifu_resp_err;

  logic                      lsu_req_valid;
  logic                      lsu_req_ready;
  logic [ADDR_WIDTH-1:0]     lsu_addr;
  logic                      lsu_wen;
  logic [DATA_WIDTH-1:0]     lsu_wdata;
  logic [DATA_WIDTH/8-1:0]   lsu_wmask;
  logic                      lsu_resp_valid;
  logic [DATA_WIDTH-1:0]     lsu_rdata;
  logic                      lsu_resp_err;

  logic                      mem_req_valid;
  logic                      mem_req_ready;
  logic [ADDR_WIDTH-1:0]     mem_addr;
  logic                      mem_wen;
  logic [DATA_WIDTH-1:0]     mem_wdata;
  logic [DATA_WIDTH/8-1:0]   mem_wmask;
  logic                      mem_resp_valid;
  logic [DATA_WIDTH-1:0]     mem_rdata;

  modport slave (
    input  ifu_req_valid, ifu_addr,
    input  lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    input  mem_req_ready, mem_resp_valid, mem_rdata,
    output ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    output lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    output mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );

  modport master (
    output ifu_req_valid, ifu_addr,
    output lsu_req_valid, lsu_addr, lsu_wen, lsu_wdata, lsu_wmask,
    output mem_req_ready, mem_resp_valid, mem_rdata,
    input  ifu_req_ready, ifu_resp_valid, ifu_rdata, ifu_resp_err,
    input  lsu_req_ready, lsu_resp_valid, lsu_rdata, lsu_resp_err,
    input  mem_req_valid, mem_addr, mem_wen, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/ysyx_24120013_mem_arbiter.sv
// Shares the single memory port between IFU and LSU: round-robin grant in IDLE,
// issue to memory, wait for the response under a watchdog, route it to the owner.
module ysyx_24120013_mem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                       clk,
  input  logic                       rst,
  ysyx_24120013_mem_arbiter_if.slave bus,
  output logic                       busy
);
  localparam int unsigned CNT_W  = $clog2(TIMEOUT + 1);
  localparam int unsigned MASK_W = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_e;
  typedef enum logic {OWN_IFU, OWN_LSU} owner_e;

  state_e                  state_q;
  owner_e                  owner_q;
  owner_e                  last_grant_q;
  logic [CNT_W-1:0]        cnt_q;

  logic                    mem_req_valid_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic                    mem_wen_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic [MASK_W-1:0]       mem_wmask_q;

  logic                    ifu_resp_valid_q;
  logic [DATA_WIDTH-1:0]   ifu_rdata_q;
  logic                    ifu_resp_err_q;
  logic                    lsu_resp_valid_q;
  logic [DATA_WIDTH-1:0]   lsu_rdata_q;
  logic                    lsu_resp_err_q;

  logic                    ifu_win;
  logic                    lsu_win;
  logic                    resp_done;
  logic [DATA_WIDTH-1:0]   resp_data;

  // A tie goes to whichever requester was not granted last.
  always_comb begin
    ifu_win   = bus.ifu_req_valid && (!bus.lsu_req_valid || (last_grant_q == OWN_LSU));
    lsu_win   = bus.lsu_req_valid && (!bus.ifu_req_valid || (last_grant_q == OWN_IFU));
    resp_done = bus.mem_resp_valid || (cnt_q == CNT_W'(TIMEOUT));
    resp_data = bus.mem_resp_valid ? bus.mem_rdata : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      owner_q          <= OWN_IFU;
      last_grant_q     <= OWN_LSU;
      cnt_q            <= '0;
      mem_req_valid_q  <= 1'b0;
      mem_addr_q       <= '0;
      mem_wen_q        <= 1'b0;
      mem_wdata_q      <= '0;
      mem_wmask_q      <= '0;
      ifu_resp_valid_q <= 1'b0;
      ifu_rdata_q      <= '0;
      ifu_resp_err_q   <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      lsu_rdata_q      <= '0;
      lsu_resp_err_q   <= 1'b0;
    end else begin
      ifu_resp_valid_q <= 1'b0;
      lsu_resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (lsu_win) begin
            state_q         <= ISSUE;
            owner_q         <= OWN_LSU;
            last_grant_q    <= OWN_LSU;
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= bus.lsu_addr;
            mem_wen_q       <= bus.lsu_wen;
            mem_wdata_q     <= bus.lsu_wdata;
            mem_wmask_q     <= bus.lsu_wmask;
          end else if (ifu_win) begin
            state_q         <= ISSUE;
            owner_q         <= OWN_IFU;
            last_grant_q    <= OWN_IFU;
            mem_req_valid_q <= 1'b1;
            mem_addr_q      <= bus.ifu_addr;
            mem_wen_q       <= 1'b0;
            mem_wdata_q     <= '0;
            mem_wmask_q     <= '1;
          end
        end
        ISSUE: begin
          if (bus.mem_req_ready) begin
            state_q         <= WAIT;
            mem_req_valid_q <= 1'b0;
            cnt_q           <= '0;
          end
        end
        WAIT: begin
          // A data response in the timeout cycle still wins over the error.
          if (resp_done) begin
            state_q <= IDLE;
            if (owner_q == OWN_LSU) begin
              lsu_resp_valid_q <= 1'b1;
              lsu_rdata_q      <= resp_data;
              lsu_resp_err_q   <= !bus.mem_resp_valid;
            end else begin
              ifu_resp_valid_q <= 1'b1;
              ifu_rdata_q      <= resp_data;
              ifu_resp_err_q   <= !bus.mem_resp_valid;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ifu_req_ready  = (state_q == IDLE) && ifu_win;
  assign bus.lsu_req_ready  = (state_q == IDLE) && lsu_win;
  assign bus.mem_req_valid  = mem_req_valid_q;
  assign bus.mem_addr       = mem_addr_q;
  assign bus.mem_wen        = mem_wen_q;
  assign bus.mem_wdata      = mem_wdata_q;
  assign bus.mem_wmask      = mem_wmask_q;
  assign bus.ifu_resp_valid = ifu_resp_valid_q;
  assign bus.ifu_rdata      = ifu_rdata_q;
  assign bus.ifu_resp_err   = ifu_resp_err_q;
  assign bus.lsu_resp_valid = lsu_resp_valid_q;
  assign bus.lsu_rdata      = lsu_rdata_q;
  assign bus.lsu_resp_err   = lsu_resp_err_q;
  assign busy               = (state_q != IDLE);
endmodule

// File: tb/tb_ysyx_24120013_mem_arbiter.sv
// Scoreboard bench for the IFU/LSU memory arbiter: a request driver, a memory model
// that predicts each response, and a monitor that checks every response pulse.
module tb_ysyx_24120013_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = DW / 8;
  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        busy;
  int unsigned cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  ysyx_24120013_mem_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ysyx_24120013_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus),
    .busy(busy)
  );

  typedef struct {
    bit            lsu;
    logic [AW-1:0] addr;
    bit            wen;
    logic [DW-1:0] wdata;
    logic [MW-1:0] wmask;
  } req_t;

  typedef struct {
    bit            lsu;
    logic [DW-1:0] rdata;
    bit            err;
    int unsigned   at;
  } resp_t;

  req_t        mreq_q[$];
  resp_t       sb_q[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // memory model knobs: negative force values mean random
  int            force_r    = -1;
  int            force_k    = -1;
  bit            late_pulse = 1'b0;
  bit            mute       = 1'b0;
  bit            use_data   = 1'b0;
  logic [DW-1:0] data_v     = '0;

  req_t        ifu_p, lsu_p;
  bit          ifu_pend   = 1'b0;
  bit          lsu_pend   = 1'b0;
  bit          last_lsu_m = 1'b1;
  int unsigned hs_cyc     = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic req_t new_req(input bit is_lsu);
    req_t r;
    r.lsu   = is_lsu;
    r.addr  = $urandom;
    r.wen   = is_lsu ? 1'($urandom_range(0, 1)) : 1'b0;
    r.wdata = is_lsu ? $urandom : '0;
    r.wmask = is_lsu ? MW'($urandom) : '1;
    return r;
  endfunction

  task automatic drive();
    bus.ifu_req_valid = ifu_pend;
    bus.ifu_addr      = ifu_p.addr;
    bus.lsu_req_valid = lsu_pend;
    bus.lsu_addr      = lsu_p.addr;
    bus.lsu_wen       = lsu_p.wen;
    bus.lsu_wdata     = lsu_p.wdata;
    bus.lsu_wmask     = lsu_p.wmask;
  endtask

  // Called at a negedge with the arbiter idle; refill: 0 none, 1 random, 2 always.
  task automatic grant_step(input int refill);
    bit win_lsu;
    if (!ifu_pend && !lsu_pend) begin
      @(posedge clk); #1;
      ifu_pend = 1'($urandom_range(0, 1));
      if (ifu_pend) ifu_p = new_req(1'b0);
      lsu_pend = !ifu_pend || ($urandom_range(0, 1) == 1);
      if (lsu_pend) lsu_p = new_req(1'b1);
      drive();
      @(negedge clk);
    end
    win_lsu = (ifu_pend && lsu_pend) ? !last_lsu_m : lsu_pend;
    chk("grant", {bus.ifu_req_ready, bus.lsu_req_ready}, {!win_lsu, win_lsu});
    mreq_q.push_back(win_lsu ? lsu_p : ifu_p);
    last_lsu_m = win_lsu;
    hs_cyc     = cyc;
    @(posedge clk); #1;
    if (win_lsu) begin
      lsu_pend = (refill == 2) || (refill == 1 && $urandom_range(0, 1) == 1);
      if (lsu_pend) lsu_p = new_req(1'b1);
    end else begin
      ifu_pend = (refill == 2) || (refill == 1 && $urandom_range(0, 1) == 1);
      if (ifu_pend) ifu_p = new_req(1'b0);
    end
    drive();
  endtask

  task automatic wait_idle();
    bit done = 1'b0;
    @(negedge clk);
    chk("busy_after_grant", busy, 1'b1);
    for (int i = 0; i < 40 && !done; i++) begin
      if (!busy) done = 1'b1;
      else begin
        chk("ready_while_busy", {bus.ifu_req_ready, bus.lsu_req_ready}, 2'b00);
        @(negedge clk);
      end
    end
    if (!done) chk("idle_timeout", busy, 1'b0);
  endtask

  task automatic drop_requests();
    ifu_pend = 1'b0;
    lsu_pend = 1'b0;
    drive();
    #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_mem_req_valid"}, bus.mem_req_valid, 1'b0);
    chk({tag, "_mem_fields"}, {bus.mem_addr, bus.mem_wen, bus.mem_wmask}, '0);
    chk({tag, "_mem_wdata"}, bus.mem_wdata, '0);
    chk({tag, "_resp_valid"}, {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
    chk({tag, "_resp_err"}, {bus.ifu_resp_err, bus.lsu_resp_err}, 2'b00);
    chk({tag, "_ifu_rdata"}, bus.ifu_rdata, '0);
    chk({tag, "_lsu_rdata"}, bus.lsu_rdata, '0);
  endtask

  // Memory: accepts after r cycles, answers in WAIT cycle k (k > TO means never).
  initial begin : mem_model
    req_t          e;
    int            r, k;
    int unsigned   w_cyc;
    logic [DW-1:0] d;
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_rdata      = '0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && bus.mem_req_valid === 1'b1) begin
        chk("mem_req_expected", mreq_q.size() != 0, 1'b1);
        if (mreq_q.size() != 0) begin
          e = mreq_q.pop_front();
          chk("mem_addr", bus.mem_addr, e.addr);
          chk("mem_wen", bus.mem_wen, e.wen);
          chk("mem_wmask", bus.mem_wmask, e.wmask);
          if (e.lsu) chk("mem_wdata", bus.mem_wdata, e.wdata);
          r = (force_r >= 0) ? force_r : int'($urandom_range(0, 3));
          repeat (r) begin
            @(negedge clk);
            chk("mem_hold", {bus.mem_req_valid, bus.mem_addr, bus.mem_wen, bus.mem_wmask},
                {1'b1, e.addr, e.wen, e.wmask});
            if (e.lsu) chk("mem_hold_wdata", bus.mem_wdata, e.wdata);
          end
          bus.mem_req_ready = 1'b1;
          @(negedge clk);
          bus.mem_req_ready = 1'b0;
          chk("mem_req_drop", bus.mem_req_valid, 1'b0);
          w_cyc = cyc;
          k = (force_k >= 0) ? force_k : int'($urandom_range(0, TO + 2));
          if (k <= int'(TO)) begin
            repeat (k) @(negedge clk);
            d = use_data ? data_v : $urandom;
            bus.mem_resp_valid = 1'b1;
            bus.mem_rdata      = d;
            sb_q.push_back('{e.lsu, d, 1'b0, cyc + 1});
            @(negedge clk);
            bus.mem_resp_valid = 1'b0;
            bus.mem_rdata      = $urandom;
          end else if (!mute) begin
            sb_q.push_back('{e.lsu, '0, 1'b1, w_cyc + TO + 1});
            if (late_pulse) begin
              repeat (TO + 1) @(negedge clk);
              bus.mem_resp_valid = 1'b1;
              bus.mem_rdata      = $urandom;
              @(negedge clk);
              bus.mem_resp_valid = 1'b0;
            end
          end
        end
      end
    end
  end

  initial begin : monitor
    resp_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && (bus.ifu_resp_valid || bus.lsu_resp_valid)) begin
        if (sb_q.size() == 0) begin
          chk("resp_unexpected", {bus.ifu_resp_valid, bus.lsu_resp_valid}, 2'b00);
        end else begin
          e = sb_q.pop_front();
          chk("resp_owner", {bus.ifu_resp_valid, bus.lsu_resp_valid}, {!e.lsu, e.lsu});
          chk("resp_cycle", cyc, e.at);
          if (e.lsu) begin
            chk("lsu_rdata", bus.lsu_rdata, e.rdata);
            chk("lsu_err", bus.lsu_resp_err, e.err);
          end else begin
            chk("ifu_rdata", bus.ifu_rdata, e.rdata);
            chk("ifu_err", bus.ifu_resp_err, e.err);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, want finish before 200000 time units");
    $fatal(1, "bench stalled");
  end

  initial begin : main
    int unsigned prev_hs;
    ifu_p = new_req(1'b0);
    lsu_p = new_req(1'b1);
    drive();
    repeat (2) @(negedge clk);
    chk_reset_outputs("rst");
    @(posedge clk); #1;
    rst = 1'b0;

    // continuous tie: IFU first, then alternating, one grant every 3 cycles
    force_r = 0; force_k = 0;
    @(posedge clk); #1;
    ifu_pend = 1'b1; ifu_p = new_req(1'b0);
    lsu_pend = 1'b1; lsu_p = new_req(1'b1);
    drive();
    @(negedge clk);
    prev_hs = 0;
    for (int i = 0; i < 4; i++) begin
      grant_step(2);
      if (i > 0) chk("rr_spacing", hs_cyc - prev_hs, 3);
      prev_hs = hs_cyc;
      wait_idle();
    end
    drop_requests();

    // single fetch with minimum latency
    @(posedge clk); #1;
    ifu_pend = 1'b1; ifu_p = new_req(1'b0); ifu_p.addr = 32'h8000_0000;
    use_data = 1'b1; data_v = 32'h0010_0093;
    drive();
    @(negedge clk);
    grant_step(0);
    wait_idle();
    chk("fetch_latency", cyc - hs_cyc, 3);

    // store held off by memory for 4 cycles
    force_r = 4; force_k = 0; use_data = 1'b0;
    @(posedge clk); #1;
    lsu_pend = 1'b1; lsu_p = '{1'b1, 32'h8000_1000, 1'b1, 32'hDEAD_BEEF, 4'b0011};
    drive();
    @(negedge clk);
    grant_step(0);
    wait_idle();
    chk("store_latency", cyc - hs_cyc, 7);

    // timeout, followed by a late response in IDLE that must be dropped
    force_r = 0; force_k = TO + 1; late_pulse = 1'b1;
    @(posedge clk); #1;
    lsu_pend = 1'b1; lsu_p = new_req(1'b1); lsu_p.wen = 1'b0;
    drive();
    @(negedge clk);
    grant_step(0);
    wait_idle();
    chk("timeout_latency", cyc - hs_cyc, TO + 3);
    repeat (3) @(negedge clk);

    // data response in the same cycle the counter reaches TIMEOUT
    force_k = TO; use_data = 1'b1; data_v = 32'h1234_5678;
    @(posedge clk); #1;
    lsu_pend = 1'b1; lsu_p = new_req(1'b1);
    drive();
    @(negedge clk);
    grant_step(0);
    wait_idle();
    chk("collide_latency", cyc - hs_cyc, TO + 3);

    // randomized traffic
    force_r = -1; force_k = -1; use_data = 1'b0;
    for (int i = 0; i < 80; i++) begin
      grant_step(1);
      wait_idle();
    end
    drop_requests();
    repeat (TO + 4) @(negedge clk);

    // asynchronous reset in the middle of WAIT
    force_r = 0; force_k = TO + 1; mute = 1'b1; late_pulse = 1'b0;
    @(posedge clk); #1;
    ifu_pend = 1'b1; ifu_p = new_req(1'b0);
    lsu_pend = 1'b1; lsu_p = new_req(1'b1);
    drive();
    @(negedge clk);
    grant_step(0);
    repeat (3) @(negedge clk);
    chk("busy_in_wait", busy, 1'b1);
    #2 rst = 1'b1;
    #1 chk_reset_outputs("midrst");
    @(posedge clk); #1;
    rst = 1'b0;
    mute = 1'b0; force_k = 0;
    last_lsu_m = 1'b1;
    ifu_pend = 1'b1; ifu_p = new_req(1'b0);
    lsu_pend = 1'b1; lsu_p = new_req(1'b1);
    drive();
    @(negedge clk);
    grant_step(0);
    wait_idle();
    drop_requests();
    repeat (TO + 4) @(negedge clk);

    chk("scoreboard_drained", sb_q.size(), 0);
    chk("mem_queue_drained", mreq_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
